// File: rtl/vector_pkg.sv
// Shared fixed-point vector types and helpers for the shading stages.
// Q8.24 scalars, vec3 packed as {x, y, z} with x in the top 32 bits.
package vector_pkg;

    typedef logic signed [31:0] fp_t;

    localparam fp_t FP_ONE = 32'sh0100_0000;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        rgb888_t rgb;
        logic    tlast;
        logic    tuser;
    } pix_entry_t;

    // Dot product kept wide so out-of-range sums survive until they are clamped.
    function automatic logic signed [65:0] vec3_dot(input vec3_t a, input vec3_t b);
        logic signed [63:0] ax, ay, az, bx, by, bz;
        logic signed [65:0] acc;
        ax  = a.x;
        ay  = a.y;
        az  = a.z;
        bx  = b.x;
        by  = b.y;
        bz  = b.z;
        acc = 66'(ax * bx) + 66'(ay * by) + 66'(az * bz);
        return acc >>> 24;
    endfunction

    function automatic fp_t fp_clamp01(input logic signed [65:0] v);
        if (v < 66'sd0) begin
            return 32'sd0;
        end else if (v > 66'(FP_ONE)) begin
            return FP_ONE;
        end
        return fp_t'(v[31:0]);
    endfunction

    // One colour channel scaled by an intensity in [0, 1.0], saturating at 255.
    function automatic logic [7:0] shade_chan(input logic [7:0] base, input logic [24:0] inten);
        logic [32:0] prod;
        prod = 33'(base) * 33'(inten);
        return prod[32] ? 8'hFF : prod[31:24];
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO of pixel entries.
// A write while full is accepted only if a read happens in the same cycle.
module pixel_fifo
    import vector_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  pix_entry_t               wr_data,
    input  logic                     rd_en,
    output pix_entry_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    pix_entry_t    mem [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          do_wr, do_rd;

    // Occupancy flags and write/read qualification.
    always_comb begin
        level   = wptr_q - rptr_q;
        full    = (level == (AW + 1)'(DEPTH));
        empty   = (level == '0);
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        // Zero when empty so outputs stay clean after reset.
        rd_data = empty ? '0 : mem[rptr_q[AW-1:0]];
    end

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + (AW + 1)'(1);
            if (do_rd) rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/shade_pixel_stream.sv
// Lambert shading of hit/miss samples into a raster-ordered RGB888 stream.
// Three register stages (dot/clamp, intensity, colour + raster tags) feed an
// output FIFO that absorbs downstream stalls and flags dropped pixels.
// Define SHADE_HALF_LAMBERT_EN to use half-Lambert diffuse instead of a hard clamp.
module shade_pixel_stream #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] AMBIENT    = 32'h0033_3333,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter logic [23:0] COL_SPHERE = 24'hFF4020,
    parameter logic [23:0] COL_FRAME  = 24'h20A0FF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          obj_sel,
    input  logic                          valid_in,
    input  logic                          hit_in,
    input  logic [95:0]                   surfaceNormal,
    input  logic [95:0]                   surfaceLight,
    output logic [23:0]                   out_tdata,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic                          out_tlast,
    output logic                          out_tuser,
    output logic                          fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import vector_pkg::*;

    localparam int unsigned XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int unsigned YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
    localparam logic [31:0] ONE_MINUS_AMB = 32'(FP_ONE) - AMBIENT;

    // Stage 1: clamped diffuse term
    logic signed [65:0] dot_raw, diff_pre;
    fp_t                diffuse;
    logic               s1_valid_q, s1_hit_q, s1_obj_q;
    logic [24:0]        s1_diff_q;

    // Combinational diffuse from the incoming vectors.
    always_comb begin
        dot_raw  = vec3_dot(vec3_t'(surfaceNormal), vec3_t'(surfaceLight));
`ifdef SHADE_HALF_LAMBERT_EN
        diff_pre = (dot_raw >>> 1) + 66'(FP_ONE >>> 1);
`else
        diff_pre = dot_raw;
`endif
        diffuse  = fp_clamp01(diff_pre);
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_obj_q   <= 1'b0;
            s1_diff_q  <= '0;
        end else begin
            s1_valid_q <= valid_in;
            s1_hit_q   <= hit_in;
            s1_obj_q   <= obj_sel;
            s1_diff_q  <= diffuse[24:0];
        end
    end

    // Stage 2: intensity = ambient + (1 - ambient) * diffuse
    logic [63:0] scaled;
    logic [32:0] inten_sum;
    logic        s2_valid_q, s2_hit_q, s2_obj_q;
    logic [24:0] s2_inten_q;

    // Ambient-weighted intensity before clamping.
    always_comb begin
        scaled    = 64'(ONE_MINUS_AMB) * 64'(s1_diff_q);
        inten_sum = 33'(AMBIENT) + 33'(scaled >> 24);
    end

    // Stage 2 register with clamp to 1.0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_obj_q   <= 1'b0;
            s2_inten_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_hit_q   <= s1_hit_q;
            s2_obj_q   <= s1_obj_q;
            s2_inten_q <= (inten_sum > 33'(FP_ONE)) ? 25'h100_0000 : inten_sum[24:0];
        end
    end

    // Stage 3: colour, raster tags
    rgb888_t       base_rgb, shaded;
    logic          s3_valid_q;
    pix_entry_t    s3_entry_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Per-object base colour scaled by intensity; misses take the background.
    always_comb begin
        base_rgb = s2_obj_q ? rgb888_t'(COL_FRAME) : rgb888_t'(COL_SPHERE);
        shaded.r = shade_chan(base_rgb.r, s2_inten_q);
        shaded.g = shade_chan(base_rgb.g, s2_inten_q);
        shaded.b = shade_chan(base_rgb.b, s2_inten_q);
        if (!s2_hit_q) shaded = rgb888_t'(BG_COLOR);
    end

    // Stage 3 register; tags come from the raster position of this pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_valid_q <= 1'b0;
            s3_entry_q <= '0;
        end else begin
            s3_valid_q       <= s2_valid_q;
            s3_entry_q.rgb   <= shaded;
            s3_entry_q.tlast <= (x_q == X_LAST);
            s3_entry_q.tuser <= (x_q == '0) && (y_q == '0);
        end
    end

    // Raster counters advance per shaded pixel, dropped or not, to keep frame alignment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (s2_valid_q) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    // Output FIFO
    pix_entry_t fifo_rd;
    logic       fifo_full, fifo_empty, pop;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s3_valid_q),
        .wr_data (s3_entry_q),
        .rd_en   (out_tready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Stream outputs straight from the FIFO head.
    always_comb begin
        pop        = !fifo_empty && out_tready;
        out_tvalid = !fifo_empty;
        out_tdata  = fifo_rd.rgb;
        out_tlast  = fifo_rd.tlast;
        out_tuser  = fifo_rd.tuser;
    end

    // Sticky drop flag: write into a full FIFO with no simultaneous pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_overflow <= 1'b0;
        end else if (s3_valid_q && fifo_full && !pop) begin
            fifo_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shade_pixel_stream.sv
// Bench for shade_pixel_stream on a 4x2 screen with a 16-entry FIFO.
module tb_shade_pixel_stream;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 16;
    localparam longint ONE = 64'h0100_0000;
    localparam longint AMB = 64'h0033_3333;

    localparam logic [95:0] V_X  = {32'h0100_0000, 32'h0, 32'h0};
    localparam logic [95:0] V_NX = {32'hFF00_0000, 32'h0, 32'h0};
    localparam logic [95:0] V_Y  = {32'h0, 32'h0100_0000, 32'h0};
    localparam logic [95:0] V_D  = {32'h00B5_04F3, 32'h00B5_04F3, 32'h0};
    localparam logic [95:0] V_DN = {32'h00B5_04F3, 32'hFF4A_FB0D, 32'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        obj_sel = 1'b0, valid_in = 1'b0, hit_in = 1'b0, out_tready = 1'b1;
    logic [95:0] nrm = '0, lgt = '0;
    logic [23:0] out_tdata;
    logic        out_tvalid, out_tlast, out_tuser, fifo_overflow;
    logic [4:0]  fifo_level;

    shade_pixel_stream #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .obj_sel       (obj_sel),
        .valid_in      (valid_in),
        .hit_in        (hit_in),
        .surfaceNormal (nrm),
        .surfaceLight  (lgt),
        .out_tdata     (out_tdata),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_tlast     (out_tlast),
        .out_tuser     (out_tuser),
        .fifo_overflow (fifo_overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [23:0] rgb;
        bit          last;
        bit          user;
    } pix_t;

    int   total = 0;
    int   bad   = 0;
    pix_t p1, p2, p3;
    pix_t mq[$];
    pix_t obs[$];
    bit   m_ovf;
    int   pix_idx;
    logic [95:0] vtab [4];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected colour straight from the shading equations.
    function automatic logic [23:0] ref_color(bit hit, bit obj, logic [95:0] n, logic [95:0] l);
        longint d, diff, inten, ch;
        logic [23:0] col, res;
        if (!hit) return 24'h000000;
        d = (longint'($signed(n[95:64])) * longint'($signed(l[95:64]))
           + longint'($signed(n[63:32])) * longint'($signed(l[63:32]))
           + longint'($signed(n[31:0]))  * longint'($signed(l[31:0]))) >>> 24;
`ifdef SHADE_HALF_LAMBERT_EN
        d = (d >>> 1) + ONE / 2;
`endif
        diff  = (d < 0) ? 0 : (d > ONE) ? ONE : d;
        inten = AMB + (((ONE - AMB) * diff) >>> 24);
        if (inten > ONE) inten = ONE;
        col = obj ? 24'h20A0FF : 24'hFF4020;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            ch = (longint'(col[23 - 8*c -: 8]) * inten) >>> 24;
            if (ch > 255) ch = 255;
            res[23 - 8*c -: 8] = 8'(ch);
        end
        return res;
    endfunction

    // Model: 3-deep delay, then a bounded queue with drop-on-full.
    task automatic model_step();
        bit pop;
        int sz;
        if (!rst) begin
            p1.v = 0; p2.v = 0; p3.v = 0;
            mq.delete();
            m_ovf   = 0;
            pix_idx = 0;
        end else begin
            sz  = mq.size();
            pop = (sz != 0) && out_tready;
            if (pop) void'(mq.pop_front());
            if (p3.v) begin
                if (sz < DEPTH || pop) mq.push_back(p3);
                else m_ovf = 1;
            end
            p3   = p2;
            p2   = p1;
            p1.v = valid_in;
            if (valid_in) begin
                p1.rgb  = ref_color(hit_in, obj_sel, nrm, lgt);
                p1.user = (pix_idx % (W * H)) == 0;
                p1.last = (pix_idx % W) == W - 1;
                pix_idx++;
            end
        end
    endtask

    task automatic compare();
        check("tvalid", 32'(out_tvalid), 32'(mq.size() != 0));
        check("level", 32'(fifo_level), 32'(mq.size()));
        check("overflow", 32'(fifo_overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            check("tdata", 32'(out_tdata), 32'(mq[0].rgb));
            check("tlast", 32'(out_tlast), 32'(mq[0].last));
            check("tuser", 32'(out_tuser), 32'(mq[0].user));
        end else begin
            check("tdata_idle", 32'(out_tdata), 32'h0);
        end
        if (out_tvalid && out_tready) begin
            pix_t e;
            e.v = 1; e.rgb = out_tdata; e.last = out_tlast; e.user = out_tuser;
            obs.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        #1;
        compare();
    end

    task automatic send(bit hit, bit obj, logic [95:0] n, logic [95:0] l);
        valid_in = 1'b1; hit_in = hit; obj_sel = obj; nrm = n; lgt = l;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic idle(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vtab[0] = V_X; vtab[1] = V_D; vtab[2] = V_Y; vtab[3] = V_DN;
        idle(2);
        check("reset_tvalid", 32'(out_tvalid), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        rst = 1'b1;

        // Full light on the sphere: first word shows up on the 4th edge.
        send(1, 0, V_X, V_X);
        idle(2);
        check("t1_not_early", 32'(out_tvalid), 32'h0);
        idle(1);
        check("t1_tvalid", 32'(out_tvalid), 32'h1);
        check("t1_tdata", 32'(out_tdata), 32'hFF4020);
        check("t1_tuser", 32'(out_tuser), 32'h1);

        // Back-lit: ambient only. 0xFF*0x333333>>24=0x32, 0x40->0x0C, 0x20->0x06.
        send(1, 0, V_X, V_NX);
        idle(3);
        check("t2_tdata", 32'(out_tdata), 32'h320C06);

        // Miss gives background and still consumes a raster slot.
        send(0, 1, V_X, V_X);
        idle(3);
        check("t3_tvalid", 32'(out_tvalid), 32'h1);
        check("t3_tdata", 32'(out_tdata), 32'h000000);
        send(1, 1, V_X, V_X);
        idle(3);
        check("t3_next_tlast", 32'(out_tlast), 32'h1);
        check("t3_next_tdata", 32'(out_tdata), 32'h20A0FF);

        // A few partial-light patterns, model-checked.
        send(1, 0, V_D, V_X);
        send(1, 1, V_Z_or_Y(), V_X);
        send(1, 1, V_DN, V_D);
        idle(6);

        // Raster tags over a frame and into the next one.
        reset_pulse();
        obs.delete();
        for (int i = 0; i < 9; i++) send(bit'(i % 3 != 2), bit'(i % 2), vtab[i % 4], vtab[(i + 1) % 4]);
        idle(8);
        check("t4_count", 32'(obs.size()), 32'd9);
        if (obs.size() == 9) begin
            check("t4_user0", 32'(obs[0].user), 32'h1);
            check("t4_last3", 32'(obs[3].last), 32'h1);
            check("t4_user4", 32'(obs[4].user), 32'h0);
            check("t4_last7", 32'(obs[7].last), 32'h1);
            check("t4_user8", 32'(obs[8].user), 32'h1);
        end

        // Stall with 17 pixels into a 16-deep FIFO.
        reset_pulse();
        out_tready = 1'b0;
        send(1, 0, V_X, V_X);
        for (int i = 1; i < 17; i++) send(bit'(i % 4 != 3), bit'(i % 2), vtab[i % 4], vtab[(i + 2) % 4]);
        idle(4);
        check("t5_level", 32'(fifo_level), 32'd16);
        check("t5_overflow", 32'(fifo_overflow), 32'h1);
        check("t5_head", 32'(out_tdata), 32'hFF4020);
        idle(3);
        check("t5_head_stable", 32'(out_tdata), 32'hFF4020);
        check("t5_user_stable", 32'(out_tuser), 32'h1);
        obs.delete();
        out_tready = 1'b1;
        idle(20);
        check("t5_drained", 32'(obs.size()), 32'd16);
        if (obs.size() != 0) check("t5_first", 32'(obs[0].rgb), 32'hFF4020);
        check("t5_sticky", 32'(fifo_overflow), 32'h1);

        // Reset with a partly full FIFO.
        out_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(1, bit'(i % 2), vtab[i % 4], V_X);
        idle(5);
        check("t6_level_before", 32'(fifo_level), 32'd5);
        reset_pulse();
        check("t6_tvalid", 32'(out_tvalid), 32'h0);
        check("t6_level", 32'(fifo_level), 32'h0);
        check("t6_overflow", 32'(fifo_overflow), 32'h0);
        out_tready = 1'b1;
        obs.delete();
        send(1, 0, V_X, V_X);
        idle(5);
        check("t6_count", 32'(obs.size()), 32'd1);
        if (obs.size() != 0) begin
            check("t6_tuser", 32'(obs[0].user), 32'h1);
            check("t6_tdata", 32'(obs[0].rgb), 32'hFF4020);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Perpendicular pair partner: N along Y against L along X gives d = 0.
    function automatic logic [95:0] V_Z_or_Y();
        return V_Y;
    endfunction

endmodule
